// File: rtl/cnn_stream_driver.sv
// cnn_stream_driver: host-side feeder for the CNN core. Reads seven parameter/image
// lanes from 1-cycle-latency memories through one shared address, streams them to
// the core in a single burst, then waits for the core's finish and captures its class.
//
// Handshake: go is a single-cycle request with no ready; it is accepted only when the
// FSM sits in S_IDLE (busy low) and is otherwise dropped. cnn_data_valid qualifies
// lane_data_out for exactly one cycle per beat; the core has no backpressure.
module cnn_stream_driver #(
  parameter int DATA_WIDTH     = 16,
  parameter int IMG_WORDS      = 784,
  parameter int W1_WORDS       = 50,
  parameter int B1_WORDS       = 2,
  parameter int W2_WORDS       = 54,
  parameter int B2_WORDS       = 3,
  parameter int WFC_WORDS      = 750,
  parameter int BFC_WORDS      = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    go,
  output logic                    busy,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [7*DATA_WIDTH-1:0] lane_rdata,
  output logic                    cnn_start,
  output logic                    cnn_data_valid,
  output logic [7*DATA_WIDTH-1:0] lane_data_out,
  input  logic                    cnn_finish,
  input  logic [3:0]              cnn_class_in,
  output logic                    result_valid,
  output logic [3:0]              class_result,
  output logic                    timeout_err,
  output logic [1:0]              dbg_state
);

  // Word count of each lane, indexed by lane number.
  function automatic int lane_len(input int n);
    case (n)
      0:       return IMG_WORDS;
      1:       return W1_WORDS;
      2:       return B1_WORDS;
      3:       return W2_WORDS;
      4:       return B2_WORDS;
      5:       return WFC_WORDS;
      default: return BFC_WORDS;
    endcase
  endfunction

  // The burst length is set by the longest lane; shorter lanes are zero-padded.
  function automatic int burst_len();
    int m;
    m = 0;
    for (int n = 0; n < 7; n++) begin
      if (lane_len(n) > m) m = lane_len(n);
    end
    return m;
  endfunction

  localparam int N  = burst_len();
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [TW-1:0]         TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]         TO_ONE    = TW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]    state;
  logic [TW-1:0] wait_cnt;
  logic [6:0]    beat_mask;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Control FSM: address generation, start pulse, finish capture and timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      cnn_start    <= 1'b0;
      wait_cnt     <= '0;
      result_valid <= 1'b0;
      class_result <= '0;
      timeout_err  <= 1'b0;
    end else begin
      cnn_start    <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_STREAM;
            cnn_start <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
          end
        end
        S_STREAM: begin
          // Address saturates at the last beat; it never wraps.
          if (mem_addr == ADDR_LAST) begin
            mem_rd_en <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          // Finish takes priority over a timeout landing in the same cycle.
          if (cnn_finish) begin
            class_result <= cnn_class_in;
            result_valid <= 1'b1;
            state        <= S_IDLE;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay rd_en and the per-lane "beat within lane length" flags by the memory latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnn_data_valid <= 1'b0;
      beat_mask      <= '0;
    end else begin
      cnn_data_valid <= mem_rd_en;
      for (int n = 0; n < 7; n++) begin
        beat_mask[n] <= mem_rd_en && (32'(mem_addr) < $unsigned(lane_len(n)));
      end
    end
  end

  // Pass memory data through on valid beats of each lane, zero otherwise.
  always_comb begin
    lane_data_out = '0;
    for (int n = 0; n < 7; n++) begin
      if (cnn_data_valid && beat_mask[n]) begin
        lane_data_out[n*DATA_WIDTH +: DATA_WIDTH] = lane_rdata[n*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cnn_stream_driver.sv
// Testbench for cnn_stream_driver: table of scenarios plus randomized runs, scored
// against expected beat streams derived from memory contents and lane lengths.
module tb_cnn_stream_driver;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int N  = 784;
  localparam int TO = 100;

  typedef struct {
    bit       fin_en;
    int       delay;
    logic [3:0] cls;
    int       go_len;
    bit       mid_go;
    bit       noise;
    bit       ret_go;
    bit       exp_to;
    logic [3:0] exp_cls;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            go = 1'b0;
  logic            busy;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [7*DW-1:0] lane_rdata = '0;
  logic            cnn_start;
  logic            cnn_data_valid;
  logic [7*DW-1:0] lane_data_out;
  logic            cnn_finish = 1'b0;
  logic [3:0]      cnn_class_in = '0;
  logic            result_valid;
  logic [3:0]      class_result;
  logic            timeout_err;
  logic [1:0]      dbg_state;

  logic [DW-1:0]   rom [7][1024];
  logic [7*DW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt, beat_cnt, start_cnt = 0;
  int first_rd_cyc, first_beat_cyc, last_beat_cyc;
  logic [3:0] prev_cls;
  vec_t tbl [6];

  cnn_stream_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .lane_rdata(lane_rdata),
    .cnn_start(cnn_start), .cnn_data_valid(cnn_data_valid), .lane_data_out(lane_data_out),
    .cnn_finish(cnn_finish), .cnn_class_in(cnn_class_in), .result_valid(result_valid),
    .class_result(class_result), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Seven synchronous memories with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int n = 0; n < 7; n++) lane_rdata[n*DW +: DW] <= rom[n][mem_addr];
    end
  end

  function automatic int lane_len(input int n);
    case (n)
      0: return 784;  1: return 50;  2: return 2;  3: return 54;
      4: return 3;    5: return 750; default: return 10;
    endcase
  endfunction

  // Expected beat k: each lane carries its word k while k is inside the lane, else 0
  function automatic logic [7*DW-1:0] beat_of(input int k);
    logic [7*DW-1:0] b;
    b = '0;
    for (int n = 0; n < 7; n++) b[n*DW +: DW] = (k < lane_len(n)) ? rom[n][k] : '0;
    return b;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_rd_en"}, 128'(mem_rd_en), 128'(0));
    check({tag, "_addr"}, 128'(mem_addr), 128'(0));
    check({tag, "_start"}, 128'(cnn_start), 128'(0));
    check({tag, "_valid"}, 128'(cnn_data_valid), 128'(0));
    check({tag, "_lanes"}, 128'(lane_data_out), 128'(0));
    check({tag, "_result_valid"}, 128'(result_valid), 128'(0));
    check({tag, "_class"}, 128'(class_result), 128'(0));
    check({tag, "_timeout"}, 128'(timeout_err), 128'(0));
  endtask

  // Scoreboard monitor: address sequence, beat data, idle zeroing, start pulses
  always @(negedge clk) begin
    if (cnn_start) start_cnt++;
    if (mem_rd_en) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      check("rd_addr", 128'(mem_addr), 128'(rd_cnt));
      rd_cnt++;
    end
    if (cnn_data_valid) begin
      if (beat_cnt == 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: valid beat %0d with nothing expected (cycle %0d)", beat_cnt, cyc);
      end else begin
        check("beat", 128'(lane_data_out), 128'(exp_q.pop_front()));
      end
      beat_cnt++;
    end else begin
      check("idle_lanes_zero", 128'(lane_data_out), 128'(0));
    end
  end

  // One full inference: go, stream, wait phase with finish/timeout per the record
  task automatic do_run(input vec_t v);
    int g, done_c, s0;
    for (int k = 0; k < N; k++) exp_q.push_back(beat_of(k));
    rd_cnt = 0;
    beat_cnt = 0;
    s0 = start_cnt;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 g = cyc;
    for (int j = 1; j <= N + 1; j++) begin
      go = (j < v.go_len) || (v.mid_go && j == 300);
      cnn_finish = v.noise;
      cnn_class_in = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (j == 1) begin
        check("start_pulse", 128'(cnn_start), 128'(1));
        check("busy_on", 128'(busy), 128'(1));
      end
      if (j == 2) check("start_once", 128'(cnn_start), 128'(0));
      @(posedge clk); #1;
    end
    go = 1'b0;
    cnn_finish = 1'b0;
    check("beats_left", 128'(exp_q.size()), 128'(0));
    check("beat_count", 128'(beat_cnt), 128'(N));
    check("rd_count", 128'(rd_cnt), 128'(N));
    check("first_rd_cycle", 128'(first_rd_cyc), 128'(g));
    check("first_beat_cycle", 128'(first_beat_cyc), 128'(g + 1));
    check("last_beat_cycle", 128'(last_beat_cyc), 128'(g + N));
    done_c = v.exp_to ? TO : v.delay + 1;
    for (int c = 0; c <= TO + 1; c++) begin
      cnn_finish = v.fin_en && (c == v.delay);
      cnn_class_in = cnn_finish ? v.cls : 4'($urandom_range(0, 15));
      go = v.ret_go && (c == done_c - 1);
      @(negedge clk);
      check("result_valid", 128'(result_valid), 128'(!v.exp_to && c == done_c));
      check("timeout_err", 128'(timeout_err), 128'(v.exp_to && c == TO));
      check("busy_wait", 128'(busy), 128'(c < done_c));
      @(posedge clk); #1;
    end
    cnn_finish = 1'b0;
    go = 1'b0;
    check("class_result", 128'(class_result), 128'(v.exp_cls));
    check("start_count", 128'(start_cnt - s0), 128'(1));
    check("rd_total", 128'(rd_cnt), 128'(N));
  endtask

  // Abort a run with reset around beat 400
  task automatic reset_mid_run();
    for (int k = 0; k < N; k++) exp_q.push_back(beat_of(k));
    rd_cnt = 0;
    beat_cnt = 0;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int i = 0; i < N + 50 && beat_cnt < 400; i++) @(negedge clk);
    check("reach_beat_400", 128'(beat_cnt >= 400), 128'(1));
    #2 reset_n = 1'b0;
    #1 check_all_zero("abort");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    prev_cls = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // fin_en delay cls go_len mid_go noise ret_go exp_to exp_cls
    tbl[0] = '{1'b1, 50,  4'd7,  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7};
    tbl[1] = '{1'b0, 0,   4'd0,  1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7};
    tbl[2] = '{1'b1, 99,  4'd3,  1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3};
    tbl[3] = '{1'b1, 100, 4'd9,  1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3};
    tbl[4] = '{1'b1, 0,   4'd12, 3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12};
    tbl[5] = '{1'b1, 20,  4'd5,  1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5};

    for (int n = 0; n < 7; n++)
      for (int k = 0; k < 1024; k++) rom[n][k] = DW'(k + 1);

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) do_run(tbl[i]);
    prev_cls = tbl[5].exp_cls;

    reset_mid_run();
    check_all_zero("after_abort");

    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 7; n++)
        for (int k = 0; k < 1024; k++) rom[n][k] = DW'($urandom);
      v.fin_en = ($urandom_range(0, 3) != 0);
      v.delay  = $urandom_range(0, 110);
      v.cls    = 4'($urandom_range(0, 15));
      v.go_len = $urandom_range(1, 3);
      v.mid_go = 1'($urandom_range(0, 1));
      v.noise  = 1'($urandom_range(0, 1));
      v.ret_go = 1'($urandom_range(0, 1));
      v.exp_to = !(v.fin_en && v.delay < TO);
      v.exp_cls = v.exp_to ? prev_cls : v.cls;
      do_run(v);
      prev_cls = v.exp_cls;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
